// File: rtl/phase_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// phase_sweep_scheduler : steps a calibration FSM's phase shift across a range,
// collecting a fixed number of trigger edges at each step.   Revision 1.0
// ============================================================================
module phase_sweep_scheduler #(
   parameter int SHIFT_W = 16,
   parameter int CNT_W   = 16
) (
   input  logic               clock,
   input  logic               reset_signal,
   input  logic               sweep_start,
   input  logic               sweep_abort,
   input  logic [SHIFT_W-1:0] shift_first,
   input  logic [SHIFT_W-1:0] shift_last,
   input  logic [SHIFT_W-1:0] shift_step,
   input  logic [CNT_W-1:0]   triggers_per_step,
   input  logic [CNT_W-1:0]   settle_cycles,
   input  logic               trigger_in,
   output logic               fsm_reset,
   output logic               fsm_start,
   output logic [SHIFT_W-1:0] phase_shift,
   output logic               busy,
   output logic               step_done,
   output logic               sweep_done,
   output logic [CNT_W-1:0]   step_index,
   output logic [2:0]         sched_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_ARM    = 3'd3,
      S_COUNT  = 3'd4,
      S_NEXT   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
   localparam logic [SHIFT_W-1:0] SHIFT_ONE = 1;

   state_t             state_q, state_d;
   logic [SHIFT_W-1:0] cur_q, cur_d;
   logic [SHIFT_W-1:0] last_q, last_d;
   logic [SHIFT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
   logic [CNT_W-1:0]   step_index_q, step_index_d;
   logic [SHIFT_W-1:0] phase_shift_q, phase_shift_d;
   logic               trig_prev_q, trig_prev_d;
   logic               fsm_reset_q, fsm_reset_d;
   logic               fsm_start_q, fsm_start_d;
   logic               busy_q, busy_d;
   logic               step_done_q, step_done_d;
   logic               sweep_done_q, sweep_done_d;

   logic               trig_edge;
   logic [CNT_W-1:0]   trig_cnt_inc;
   logic [SHIFT_W:0]   next_sum;

   assign trig_edge    = trigger_in & ~trig_prev_q;
   assign trig_cnt_inc = trig_cnt_q + CNT_ONE;
   // One extra bit so a step past the top of the range cannot wrap back in.
   assign next_sum     = {1'b0, cur_q} + {1'b0, step_q};

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      last_d        = last_q;
      step_d        = step_q;
      k_d           = k_q;
      settle_d      = settle_q;
      settle_cnt_d  = settle_cnt_q;
      trig_cnt_d    = trig_cnt_q;
      step_index_d  = step_index_q;
      phase_shift_d = phase_shift_q;
      trig_prev_d   = trigger_in;
      fsm_reset_d   = 1'b0;
      fsm_start_d   = 1'b0;
      step_done_d   = 1'b0;
      sweep_done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sweep_start && !sweep_abort) begin
               cur_d        = shift_first;
               last_d       = shift_last;
               step_d       = (shift_step == '0) ? SHIFT_ONE : shift_step;
               k_d          = (triggers_per_step == '0) ? CNT_ONE : triggers_per_step;
               settle_d     = (settle_cycles == '0) ? CNT_ONE : settle_cycles;
               step_index_d = '0;
               fsm_reset_d  = 1'b1;
               if (shift_first > shift_last) begin
                  state_d      = S_DONE;
                  sweep_done_d = 1'b1;
               end else begin
                  state_d       = S_LOAD;
                  phase_shift_d = shift_first;
               end
            end
         end
         S_LOAD: begin
            settle_cnt_d = settle_q;
            state_d      = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt_q <= CNT_ONE) begin
               state_d     = S_ARM;
               fsm_start_d = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q - CNT_ONE;
            end
         end
         S_ARM: begin
            trig_cnt_d = '0;
            state_d    = S_COUNT;
         end
         S_COUNT: begin
            if (trig_edge) begin
               trig_cnt_d = trig_cnt_inc;
               if (trig_cnt_inc == k_q) begin
                  step_done_d = 1'b1;
                  state_d     = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            fsm_reset_d = 1'b1;
            if (next_sum > {1'b0, last_q}) begin
               state_d      = S_DONE;
               sweep_done_d = 1'b1;
            end else begin
               cur_d         = next_sum[SHIFT_W-1:0];
               phase_shift_d = next_sum[SHIFT_W-1:0];
               step_index_d  = step_index_q + CNT_ONE;
               state_d       = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over whatever the active state decided this cycle.
      if (sweep_abort && (state_q != S_IDLE)) begin
         state_d       = S_IDLE;
         cur_d         = cur_q;
         phase_shift_d = phase_shift_q;
         step_index_d  = step_index_q;
         fsm_reset_d   = 1'b1;
         fsm_start_d   = 1'b0;
         step_done_d   = 1'b0;
         sweep_done_d  = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset_signal) begin
         state_q       <= S_IDLE;
         cur_q         <= '0;
         last_q        <= '0;
         step_q        <= '0;
         k_q           <= '0;
         settle_q      <= '0;
         settle_cnt_q  <= '0;
         trig_cnt_q    <= '0;
         step_index_q  <= '0;
         phase_shift_q <= '0;
         trig_prev_q   <= 1'b0;
         fsm_reset_q   <= 1'b0;
         fsm_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         step_done_q   <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         last_q        <= last_d;
         step_q        <= step_d;
         k_q           <= k_d;
         settle_q      <= settle_d;
         settle_cnt_q  <= settle_cnt_d;
         trig_cnt_q    <= trig_cnt_d;
         step_index_q  <= step_index_d;
         phase_shift_q <= phase_shift_d;
         trig_prev_q   <= trig_prev_d;
         fsm_reset_q   <= fsm_reset_d;
         fsm_start_q   <= fsm_start_d;
         busy_q        <= busy_d;
         step_done_q   <= step_done_d;
         sweep_done_q  <= sweep_done_d;
      end
   end

   assign fsm_reset   = fsm_reset_q;
   assign fsm_start   = fsm_start_q;
   assign phase_shift = phase_shift_q;
   assign busy        = busy_q;
   assign step_done   = step_done_q;
   assign sweep_done  = sweep_done_q;
   assign step_index  = step_index_q;
   assign sched_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// tb_phase_sweep_scheduler : directed and randomized sweeps against a
// range-enumeration model of the scheduler.   Revision 1.0
// ============================================================================
module tb_phase_sweep_scheduler;

   logic        clock = 1'b0;
   logic        reset_signal;
   logic        sweep_start;
   logic        sweep_abort;
   logic [15:0] shift_first;
   logic [15:0] shift_last;
   logic [15:0] shift_step;
   logic [15:0] triggers_per_step;
   logic [15:0] settle_cycles;
   logic        trigger_in;
   logic        fsm_reset;
   logic        fsm_start;
   logic [15:0] phase_shift;
   logic        busy;
   logic        step_done;
   logic        sweep_done;
   logic [15:0] step_index;
   logic [2:0]  sched_state;

   phase_sweep_scheduler #(.SHIFT_W(16), .CNT_W(16)) dut (
      .clock             (clock),
      .reset_signal      (reset_signal),
      .sweep_start       (sweep_start),
      .sweep_abort       (sweep_abort),
      .shift_first       (shift_first),
      .shift_last        (shift_last),
      .shift_step        (shift_step),
      .triggers_per_step (triggers_per_step),
      .settle_cycles     (settle_cycles),
      .trigger_in        (trigger_in),
      .fsm_reset         (fsm_reset),
      .fsm_start         (fsm_start),
      .phase_shift       (phase_shift),
      .busy              (busy),
      .step_done         (step_done),
      .sweep_done        (sweep_done),
      .step_index        (step_index),
      .sched_state       (sched_state)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Observation side: everything is sampled on the falling edge.
   int   cycle = 0;
   int   mon_starts, mon_resets, mon_step_dones, mon_sweep_dones, mon_done_cycle;
   int   mon_phases[$];
   int   mon_idx[$];
   int   settle_run = 0;
   int   exp_settle = 1;
   int   exp_k = 1;
   int   edges_in_step = 0;
   logic prev_trig_m = 1'b0;

   task automatic clear_monitor();
      mon_starts      = 0;
      mon_resets      = 0;
      mon_step_dones  = 0;
      mon_sweep_dones = 0;
      mon_done_cycle  = 0;
      mon_phases      = {};
      mon_idx         = {};
      edges_in_step   = 0;
      settle_run      = 0;
   endtask

   always @(negedge clock) begin
      cycle++;
      if (reset_signal) begin
         prev_trig_m   = 1'b0;
         settle_run    = 0;
         edges_in_step = 0;
      end else begin
         chk("busy_vs_state", busy, (sched_state != 3'd0));
         chk("start_reset_overlap", fsm_start & fsm_reset, 0);
         if (fsm_start) begin
            mon_starts++;
            mon_phases.push_back(int'(phase_shift));
            mon_idx.push_back(int'(step_index));
         end
         if (fsm_reset) mon_resets++;
         if (step_done) begin
            mon_step_dones++;
            chk("edges_per_step", edges_in_step, exp_k);
            edges_in_step = 0;
         end
         if (sweep_done) begin
            mon_sweep_dones++;
            mon_done_cycle = cycle;
         end
         if (sched_state == 3'd2) settle_run++;
         else if (settle_run != 0) begin
            chk("settle_len", settle_run, exp_settle);
            settle_run = 0;
         end
         if (sched_state == 3'd4 && trigger_in && !prev_trig_m) edges_in_step++;
         prev_trig_m = trigger_in;
      end
   end

   // Periodic trigger source; period 0 leaves trigger_in to the test sequence.
   int trig_period = 0;
   initial begin
      int ph;
      ph = 0;
      trigger_in = 1'b0;
      forever begin
         tick();
         if (trig_period > 0) begin
            ph++;
            if (ph >= trig_period) ph = 0;
            trigger_in = (ph == 0);
         end
      end
   end

   task automatic set_inputs(input int first, input int last, input int step,
                             input int k, input int settle);
      shift_first       = 16'(first);
      shift_last        = 16'(last);
      shift_step        = 16'(step);
      triggers_per_step = 16'(k);
      settle_cycles     = 16'(settle);
   endtask

   task automatic scramble_inputs();
      set_inputs(int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom_range(1, 9)), int'($urandom_range(0, 9)));
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while (mon_sweep_dones == 0 && guard < 20000) begin
         tick();
         guard++;
      end
      chk(tag, (guard < 20000), 1);
   endtask

   task automatic run_sweep(input int first, input int last, input int step,
                            input int k, input int settle, input int period);
      int exp_ph[$];
      int n, step_eff, start_cyc;
      step_eff = (step == 0) ? 1 : step;
      exp_ph = {};
      for (longint v = first; v <= last; v += step_eff) exp_ph.push_back(int'(v));
      n = exp_ph.size();
      exp_k      = (k == 0) ? 1 : k;
      exp_settle = (settle == 0) ? 1 : settle;

      clear_monitor();
      trig_period = period;
      tick();
      set_inputs(first, last, step, k, settle);
      sweep_start = 1'b1;
      start_cyc = cycle;
      tick();
      sweep_start = 1'b0;
      scramble_inputs();
      if (n > 0) begin
         tick();
         sweep_start = 1'b1;
         tick();
         sweep_start = 1'b0;
      end
      wait_done("sweep_timeout");
      tick();
      tick();

      chk("step_done_count", mon_step_dones, n);
      chk("sweep_done_count", mon_sweep_dones, 1);
      chk("fsm_start_count", mon_starts, n);
      chk("fsm_reset_count", mon_resets, n + 1);
      for (int i = 0; i < n && i < mon_phases.size(); i++) begin
         chk("step_phase", mon_phases[i], exp_ph[i]);
         chk("step_idx", mon_idx[i], i);
      end
      chk("final_index", step_index, (n == 0) ? 0 : n - 1);
      if (n > 0) chk("final_phase", phase_shift, exp_ph[n-1]);
      else chk("empty_done_latency", mon_done_cycle - start_cyc, 2);
      chk("back_to_idle", sched_state, 0);
   endtask

   task automatic wait_state(input logic [2:0] st, input string tag);
      int guard;
      guard = 0;
      while (sched_state != st && guard < 2000) begin
         tick();
         guard++;
      end
      chk(tag, (guard < 2000), 1);
   endtask

   initial begin
      reset_signal = 1'b1;
      sweep_start  = 1'b0;
      sweep_abort  = 1'b0;
      set_inputs(0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("rst_state", sched_state, 0);
      chk("rst_phase", phase_shift, 0);
      chk("rst_index", step_index, 0);
      chk("rst_outs", {fsm_reset, fsm_start, busy, step_done, sweep_done}, 0);
      reset_signal = 1'b0;
      tick();

      run_sweep(139, 141, 1, 2, 4, 120);
      run_sweep(10, 15, 4, 1, 2, 3);
      run_sweep(16'hFFFE, 16'hFFFF, 3, 1, 1, 4);
      run_sweep(5, 4, 1, 1, 3, 3);

      // Abort after one of three edges.
      clear_monitor();
      trig_period = 0;
      trigger_in  = 1'b0;
      exp_k = 3;
      exp_settle = 2;
      tick();
      set_inputs(100, 110, 1, 3, 2);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      wait_state(3'd4, "abort_reach_count");
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      tick();
      chk("abort_edges_seen", edges_in_step, 1);
      sweep_abort = 1'b1;
      tick();
      sweep_abort = 1'b0;
      chk("abort_state", sched_state, 0);
      chk("abort_fsm_reset", fsm_reset, 1);
      chk("abort_busy", busy, 0);
      repeat (3) tick();
      chk("abort_no_step_done", mon_step_dones, 0);
      chk("abort_no_sweep_done", mon_sweep_dones, 0);
      run_sweep(7, 7, 1, 1, 1, 3);

      // Start and abort together in IDLE.
      set_inputs(1, 3, 1, 1, 1);
      sweep_start = 1'b1;
      sweep_abort = 1'b1;
      tick();
      sweep_start = 1'b0;
      sweep_abort = 1'b0;
      chk("start_abort_idle", sched_state, 0);
      chk("start_abort_busy", busy, 0);

      // Zero K and zero settle with trigger already high through ARM.
      clear_monitor();
      trig_period = 0;
      trigger_in  = 1'b1;
      exp_k = 1;
      exp_settle = 1;
      tick();
      set_inputs(20, 20, 0, 0, 0);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      wait_state(3'd4, "k0_reach_count");
      repeat (3) tick();
      chk("held_high_no_step", mon_step_dones, 0);
      trigger_in = 1'b0;
      tick();
      trigger_in = 1'b1;
      wait_done("k0_timeout");
      tick();
      chk("k0_step_done", mon_step_dones, 1);
      chk("k0_phase", mon_phases.size() > 0 ? mon_phases[0] : -1, 20);
      trigger_in = 1'b0;

      // Reset in the middle of a sweep.
      clear_monitor();
      exp_k = 2;
      exp_settle = 1;
      trig_period = 3;
      tick();
      set_inputs(300, 400, 2, 2, 1);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      wait_state(3'd4, "rst_reach_count");
      reset_signal = 1'b1;
      tick();
      chk("midrst_state", sched_state, 0);
      chk("midrst_phase", phase_shift, 0);
      chk("midrst_outs", {fsm_reset, fsm_start, busy, step_done, sweep_done}, 0);
      reset_signal = 1'b0;
      repeat (4) tick();
      chk("midrst_no_done", mon_sweep_dones, 0);

      for (int r = 0; r < 14; r++) begin
         int f, l;
         f = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 5) == 0 && f > 0) l = f - int'($urandom_range(1, 5));
         else l = f + int'($urandom_range(0, 12));
         if (l < 0) l = 0;
         if (l > 65535) l = 65535;
         run_sweep(f, l, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), int'($urandom_range(2, 6)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
